// File: rtl/i2s_rx_param.sv
// I2S / left-justified master receiver: generates scki, bck and lrck from clk,
// deserialises din into left/right samples and hands each pair out on a
// valid/ready handshake with sticky overrun detection.
module i2s_rx_param #(
   parameter int unsigned WIDTH   = 24,
   parameter int unsigned SLOT    = 32,
   parameter int unsigned BCK_DIV = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             justify,
   input  logic             sample_ready,
   output logic             scki,
   output logic             bck,
   output logic             lrck,
   output logic [WIDTH-1:0] left,
   output logic [WIDTH-1:0] right,
   output logic             sample_valid,
   output logic             overrun
);

   localparam int unsigned DW = $clog2(BCK_DIV);
   localparam int unsigned BW = $clog2(2 * SLOT);

   localparam logic [DW-1:0] DCNT_LAST = DW'(BCK_DIV - 1);
   localparam logic [DW-1:0] DCNT_RISE = DW'(BCK_DIV / 2 - 1);
   localparam logic [DW-1:0] DCNT_HIGH = DW'(BCK_DIV / 2);
   localparam logic [BW-1:0] BCNT_LAST = BW'(2 * SLOT - 1);
   localparam logic [BW-1:0] BCNT_SLOT = BW'(SLOT);
   localparam logic [BW-1:0] BCNT_W    = BW'(WIDTH);

   logic [DW-1:0]    dcnt;
   logic [BW-1:0]    bcnt;
   logic             mode;
   logic [WIDTH-1:0] shl;
   logic [WIDTH-1:0] shr;
   logic             frame_done;

   logic             dcnt_wrap_c;
   logic             bck_rise_c;
   logic             frame_wrap_c;
   logic [DW-1:0]    dcnt_nxt_c;
   logic [BW-1:0]    bcnt_nxt_c;
   logic             in_right_c;
   logic [BW-1:0]    slot_k_c;
   logic [BW-1:0]    off_c;
   logic             capture_c;

   // Counter next-state, bck edge detection and capture-window decode
   always_comb begin
      dcnt_wrap_c  = 1'b0;
      bck_rise_c   = 1'b0;
      frame_wrap_c = 1'b0;
      dcnt_nxt_c   = dcnt + DW'(1);
      bcnt_nxt_c   = bcnt;
      in_right_c   = 1'b0;
      slot_k_c     = bcnt;
      off_c        = BW'(1);
      capture_c    = 1'b0;

      dcnt_wrap_c = (dcnt == DCNT_LAST);
      bck_rise_c  = (dcnt == DCNT_RISE);
      if (dcnt_wrap_c) begin
         dcnt_nxt_c = '0;
         if (bcnt == BCNT_LAST) begin
            bcnt_nxt_c   = '0;
            frame_wrap_c = 1'b1;
         end else begin
            bcnt_nxt_c = bcnt + BW'(1);
         end
      end

      in_right_c = (bcnt >= BCNT_SLOT);
      if (in_right_c) begin
         slot_k_c = bcnt - BCNT_SLOT;
      end
      // left-justified puts the MSB in slot bit 0, I2S delays it by one bck
      if (mode) begin
         off_c = '0;
      end
      capture_c = bck_rise_c && (slot_k_c >= off_c) && (slot_k_c < (off_c + BCNT_W));
   end

   // Clock divider, bit/frame counters and generated clocks
   always_ff @(posedge clk) begin
      if (reset) begin
         dcnt <= '0;
         bcnt <= '0;
         scki <= 1'b0;
         bck  <= 1'b0;
         lrck <= 1'b0;
      end else begin
         dcnt <= dcnt_nxt_c;
         bcnt <= bcnt_nxt_c;
         scki <= ~scki;
         bck  <= (dcnt_nxt_c >= DCNT_HIGH);
         lrck <= (bcnt_nxt_c >= BCNT_SLOT);
      end
   end

   // Framing mode is only allowed to change on a frame boundary
   always_ff @(posedge clk) begin
      if (reset) begin
         mode <= 1'b0;
      end else if (frame_wrap_c) begin
         mode <= justify;
      end
   end

   // MSB-first deserialisers; a full WIDTH shift fully replaces old contents
   always_ff @(posedge clk) begin
      if (reset) begin
         shl        <= '0;
         shr        <= '0;
         frame_done <= 1'b0;
      end else begin
         if (capture_c && !in_right_c) begin
            shl <= {shl[WIDTH-2:0], din};
         end
         if (capture_c && in_right_c) begin
            shr <= {shr[WIDTH-2:0], din};
         end
         frame_done <= bck_rise_c && (bcnt == BCNT_LAST);
      end
   end

   // Output pair register with valid/ready handshake and sticky overrun
   always_ff @(posedge clk) begin
      if (reset) begin
         left         <= '0;
         right        <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else if (frame_done) begin
         left         <= shl;
         right        <= shr;
         sample_valid <= 1'b1;
         if (sample_valid && !sample_ready) begin
            overrun <= 1'b1;
         end
      end else if (sample_valid && sample_ready) begin
         sample_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_i2s_rx_param.sv
// Directed bench for i2s_rx_param at default parameters (24/32/8).
module tb_i2s_rx_param;

   logic        clk;
   logic        reset;
   logic        din;
   logic        justify;
   logic        sample_ready;
   logic        scki;
   logic        bck;
   logic        lrck;
   logic [23:0] left;
   logic [23:0] right;
   logic        sample_valid;
   logic        overrun;

   int          checks;
   int          failures;
   int unsigned t;
   logic        mon_en;
   int          mm_bck;
   int          mm_scki;
   int          mm_lrck;
   int          vcount;

   logic [23:0] fl [16];
   logic [23:0] fr [16];
   logic        fj [16];

   i2s_rx_param dut (
      .clk          (clk),
      .reset        (reset),
      .din          (din),
      .justify      (justify),
      .sample_ready (sample_ready),
      .scki         (scki),
      .bck          (bck),
      .lrck         (lrck),
      .left         (left),
      .right        (right),
      .sample_valid (sample_valid),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycles since reset release: after edge n, t == n
   always @(posedge clk) begin
      if (reset) t <= 0;
      else       t <= t + 1;
   end

   // Serial source bit for time tt; unused slot bits are driven as 1
   function automatic logic fbit(input int unsigned tt);
      int unsigned f, b, k, off;
      logic [23:0] v;
      f   = (tt / 512) % 16;
      b   = (tt / 8) % 64;
      k   = b % 32;
      v   = (b >= 32) ? fr[f] : fl[f];
      off = fj[f] ? 0 : 1;
      if (k >= off && k < off + 24) return v[23 - (k - off)];
      return 1'b1;
   endfunction

   // ADC model: new bit presented on the falling clk, well before the bck rise
   always @(negedge clk) din = fbit(t);

   // Clock-shape monitor against the ideal divider timing
   always @(posedge clk) begin
      #2;
      if (mon_en && t > 0) begin
         if (bck  !== ((t % 8) >= 4))         mm_bck++;
         if (scki !== ((t % 2) == 1))         mm_scki++;
         if (lrck !== (((t / 8) % 64) >= 32)) mm_lrck++;
         if (sample_valid === 1'b1)           vcount++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_to(input int unsigned target);
      int g;
      g = 0;
      while (t != target) begin
         @(posedge clk);
         #1;
         g++;
         if (g > 4000) begin
            checks++;
            failures++;
            $error("FAIL run_to observed=%0d expected=%0d", t, target);
            break;
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_scki"},    32'(scki),         32'd0);
      chk({tag, "_bck"},     32'(bck),          32'd0);
      chk({tag, "_lrck"},    32'(lrck),         32'd0);
      chk({tag, "_left"},    32'(left),         32'd0);
      chk({tag, "_right"},   32'(right),        32'd0);
      chk({tag, "_valid"},   32'(sample_valid), 32'd0);
      chk({tag, "_overrun"}, 32'(overrun),      32'd0);
   endtask

   task automatic clr_mon();
      mm_bck = 0; mm_scki = 0; mm_lrck = 0; vcount = 0;
   endtask

   initial begin
      checks = 0; failures = 0; mon_en = 1'b0;
      clr_mon();
      for (int i = 0; i < 16; i++) begin
         fl[i] = '0; fr[i] = '0; fj[i] = 1'b0;
      end
      reset = 1'b1; justify = 1'b0; sample_ready = 1'b0; din = 1'b0;

      // A: reset, clock shape, I2S decode, simultaneous load+consume
      fl[0] = 24'hA5F00F; fr[0] = 24'h123456;
      fl[1] = 24'h5A0FF0; fr[1] = 24'hEDCBA9;
      repeat (10) @(posedge clk);
      #1;
      chk_zero("A_rst");
      reset = 1'b0; clr_mon(); mon_en = 1'b1;
      run_to(508);
      chk("A_valid_pre", 32'(sample_valid), 32'd0);
      run_to(509);
      chk("A_valid",   32'(sample_valid), 32'd1);
      chk("A_left",    32'(left),         32'hA5F00F);
      chk("A_right",   32'(right),        32'h123456);
      chk("A_overrun", 32'(overrun),      32'd0);
      run_to(1020); sample_ready = 1'b1;
      run_to(1021); sample_ready = 1'b0;
      chk("A_sim_valid",   32'(sample_valid), 32'd1);
      chk("A_sim_left",    32'(left),         32'h5A0FF0);
      chk("A_sim_right",   32'(right),        32'hEDCBA9);
      chk("A_sim_overrun", 32'(overrun),      32'd0);
      run_to(1022); sample_ready = 1'b1;
      run_to(1023); sample_ready = 1'b0;
      chk("A_cons_valid",   32'(sample_valid), 32'd0);
      chk("A_cons_overrun", 32'(overrun),      32'd0);
      chk("A_hold_left",    32'(left),         32'h5A0FF0);
      mon_en = 1'b0;
      chk("A_bck_shape",  32'(mm_bck),  32'd0);
      chk("A_scki_shape", 32'(mm_scki), 32'd0);
      chk("A_lrck_shape", 32'(mm_lrck), 32'd0);

      // B: left-justified mode, ready held high; mode after reset is I2S
      reset = 1'b1; justify = 1'b1; sample_ready = 1'b1;
      fj[0] = 1'b0; fl[0] = 24'h3C5A96; fr[0] = 24'hC3A569;
      fj[1] = 1'b1; fl[1] = 24'hA5F00F; fr[1] = 24'h123456;
      fj[2] = 1'b0; fl[2] = 24'hA5F00F; fr[2] = 24'h123456;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0; clr_mon(); mon_en = 1'b1;
      run_to(509);
      chk("B_f0_left",  32'(left),         32'h3C5A96);
      chk("B_f0_right", 32'(right),        32'hC3A569);
      chk("B_f0_valid", 32'(sample_valid), 32'd1);
      run_to(510);
      chk("B_pulse_end", 32'(sample_valid), 32'd0);
      run_to(1021);
      chk("B_lj_left",  32'(left),  32'hA5F00F);
      chk("B_lj_right", 32'(right), 32'h123456);
      run_to(1533);
      chk("B_mis_left",  32'(left),  32'hD2F807);
      chk("B_mis_right", 32'(right), 32'h891A2B);
      run_to(1540);
      mon_en = 1'b0;
      chk("B_pulses",  32'(vcount),  32'd3);
      chk("B_overrun", 32'(overrun), 32'd0);

      // C: consumer stalled across two frames
      reset = 1'b1; justify = 1'b0; sample_ready = 1'b0;
      for (int i = 0; i < 16; i++) fj[i] = 1'b0;
      fl[0] = 24'h000001; fr[0] = 24'h000010;
      fl[1] = 24'h000002; fr[1] = 24'h000020;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      run_to(509);
      chk("C_f0_left",    32'(left),    32'h000001);
      chk("C_f0_overrun", 32'(overrun), 32'd0);
      run_to(1021);
      chk("C_ovr_left",    32'(left),         32'h000002);
      chk("C_ovr_right",   32'(right),        32'h000020);
      chk("C_ovr_valid",   32'(sample_valid), 32'd1);
      chk("C_ovr_overrun", 32'(overrun),      32'd1);
      sample_ready = 1'b1;
      run_to(1022);
      sample_ready = 1'b0;
      chk("C_cons_valid",  32'(sample_valid), 32'd0);
      chk("C_sticky_ovr",  32'(overrun),      32'd1);

      // D: reset mid-frame, then justify toggled mid-frame
      reset = 1'b1;
      fl[0] = 24'h111111; fr[0] = 24'h222222;
      fl[1] = 24'h333333; fr[1] = 24'h444444;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      run_to(509);
      chk("D_pre_left", 32'(left), 32'h111111);
      run_to(812);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_zero("D_midrst");
      fl[0] = 24'h800001; fr[0] = 24'h7FFFFE;
      fl[1] = 24'hFEDCBA; fr[1] = 24'h012345;
      fj[2] = 1'b1; fl[2] = 24'h00FF00; fr[2] = 24'hFFFFFF;
      reset = 1'b0; sample_ready = 1'b1; clr_mon(); mon_en = 1'b1;
      run_to(508);
      chk("D_no_abort_valid", 32'(vcount), 32'd0);
      run_to(509);
      chk("D_f0_left",  32'(left),         32'h800001);
      chk("D_f0_right", 32'(right),        32'h7FFFFE);
      chk("D_f0_valid", 32'(sample_valid), 32'd1);
      run_to(700);
      justify = 1'b1;
      run_to(1021);
      chk("D_old_mode_left",  32'(left),  32'hFEDCBA);
      chk("D_old_mode_right", 32'(right), 32'h012345);
      run_to(1533);
      chk("D_new_mode_left",  32'(left),  32'h00FF00);
      chk("D_new_mode_right", 32'(right), 32'hFFFFFF);
      mon_en = 1'b0;
      chk("D_bck_shape",  32'(mm_bck),  32'd0);
      chk("D_lrck_shape", 32'(mm_lrck), 32'd0);
      chk("D_overrun",    32'(overrun), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
